// File: rtl/data_deconvert_fifo.sv
// Width down-converting FIFO: stores wide result words and returns them as narrow
// beats, least-significant beat first, with registered burst/room ready flags.
module data_deconvert_fifo #(
    parameter int WIDTH_IN  = 1024,
    parameter int WIDTH_OUT = 128,
    parameter int ADDR_BITS = 7,
    parameter int S_THRESH  = 120,
    localparam int RATIO    = WIDTH_IN / WIDTH_OUT,
    localparam int RB       = $clog2(RATIO),
    localparam int CW       = ADDR_BITS + RB + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Next_Reg,
    input  logic [WIDTH_IN-1:0]  din,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [WIDTH_OUT-1:0] dout,
    input  logic [CW-1:0]        M_count,
    output logic                 M_Ready,
    output logic                 S_Ready,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   wr_data_count,
    output logic [CW-1:0]        rd_data_count
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_CNT   = ADDR_BITS'(DEPTH - 1) + 1'b1;
    localparam logic [ADDR_BITS:0] THRESH_CNT = S_THRESH[ADDR_BITS:0];
    localparam logic [RB-1:0]      LAST_BEAT  = RB'(RATIO - 1);

    logic [WIDTH_IN-1:0] mem [DEPTH];

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [RB-1:0]        beat_idx_q, beat_idx_d;
    logic [ADDR_BITS:0]   wcnt_q, wcnt_d;
    logic [WIDTH_OUT-1:0] dout_q, dout_d;
    logic                 m_ready_q, m_ready_d;
    logic                 s_ready_q, s_ready_d;

    logic                 wr_ok, rd_ok, release_word;
    logic [WIDTH_IN-1:0]  rd_word;

    assign empty         = (wcnt_q == '0);
    assign full          = (wcnt_q == FULL_CNT);
    assign wr_data_count = wcnt_q;
    assign rd_data_count = {wcnt_q, {RB{1'b0}}} - CW'(beat_idx_q);
    assign dout          = dout_q;
    assign M_Ready       = m_ready_q;
    assign S_Ready       = s_ready_q;

    // A flush cycle discards both the write and the read presented with it.
    assign wr_ok        = wr_en && !full && !Next_Reg;
    assign rd_ok        = rd_en && !empty && !Next_Reg;
    assign release_word = rd_ok && (beat_idx_q == LAST_BEAT);
    assign rd_word      = mem[rd_ptr_q];

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_idx_d = beat_idx_q;
        wcnt_d     = wcnt_q;
        dout_d     = dout_q;
        m_ready_d  = (rd_data_count >= M_count);
        s_ready_d  = (wcnt_q < THRESH_CNT);

        if (Next_Reg) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            beat_idx_d = '0;
            wcnt_d     = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
            end
            if (rd_ok) begin
                dout_d = rd_word[beat_idx_q*WIDTH_OUT +: WIDTH_OUT];
                if (release_word) begin
                    beat_idx_d = '0;
                    rd_ptr_d   = rd_ptr_q + ADDR_BITS'(1);
                end else begin
                    beat_idx_d = beat_idx_q + RB'(1);
                end
            end
            // Write and release in the same cycle cancel out in the word count.
            case ({wr_ok, release_word})
                2'b10:   wcnt_d = wcnt_q + 1'b1;
                2'b01:   wcnt_d = wcnt_q - 1'b1;
                default: wcnt_d = wcnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_idx_q <= '0;
            wcnt_q     <= '0;
            dout_q     <= '0;
            m_ready_q  <= 1'b0;
            s_ready_q  <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_idx_q <= beat_idx_d;
            wcnt_q     <= wcnt_d;
            dout_q     <= dout_d;
            m_ready_q  <= m_ready_d;
            s_ready_q  <= s_ready_d;
        end
    end

    // NOTE: storage has no reset so it maps onto block RAM; the counts alone decide validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: doc/data_deconvert_fifo.md
# data_deconvert_fifo

Width down-converting FIFO on the write-back path: accepts wide result words (default 1024 bits) from the compute array and returns them as narrow beats (default 128 bits) for the DMA/AXI write side. It is the write-back counterpart of the input-side up-converting FIFO and uses the same flow-control style: M_Ready is a burst-available flag toward the back end, and S_Ready is a room-available flag toward the front end. Storage is an inferred memory of wide words. It is unpacked into narrow beats on read, least-significant beat first.

## Interface
- WIDTH_IN, 1024: wide write word width; must be WIDTH_OUT × power of 2.
- WIDTH_OUT, 128: narrow read beat width.
- ADDR_BITS, 7: log2 of depth in wide words (DEPTH = 128).
- S_THRESH, 120: S_Ready deasserts when the stored wide-word count is ≥ S_THRESH.
- Derived: RATIO = WIDTH_IN/WIDTH_OUT (8); RB = log2(RATIO) (3); CW = ADDR_BITS+RB+1 (11).

- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- Next_Reg  in  1  synchronous flush between layers; clears storage, does not touch ready flags directly.
- din  in  WIDTH_IN  wide write data.
- wr_en  in  1  write strobe; ignored when full.
- rd_en  in  1  read one narrow beat; ignored when empty.
- dout  out  WIDTH_OUT  registered narrow beat.
- M_count  in  CW  back-end burst size in narrow beats.
- M_Ready  out  1  registered; high when ≥ M_count beats are readable.
- S_Ready  out  1  registered; high when the front end may keep writing.
- empty  out  1  no readable beat.
- full  out  1  DEPTH wide words stored.
- wr_data_count  out  ADDR_BITS+1  wide words stored, 0..DEPTH.
- rd_data_count  out  CW  narrow beats readable, 0..DEPTH×RATIO.

## Operation
- State: wr_ptr and rd_ptr, each ADDR_BITS wide and wrapping modulo DEPTH. beat_idx is RB wide. wcnt has ADDR_BITS+1 bits.
- Write: when wr_en && !full, mem[wr_ptr] <= din, wr_ptr++, and wcnt increments.
- Read: when rd_en && !empty:
  - dout <= mem[rd_ptr][beat_idx×WIDTH_OUT +: WIDTH_OUT].
  - If beat_idx == RATIO-1, then beat_idx <= 0, rd_ptr++ and wcnt decrements (the wide word is released). Otherwise beat_idx++.
- Beat order per wide word: beat 0 = din[WIDTH_OUT-1:0], up to beat RATIO-1 = din[WIDTH_IN-1:WIDTH_IN-WIDTH_OUT].
- Simultaneous accepted write and releasing read: wcnt is unchanged and both pointers advance.
- Counts (combinational from state):
  - wr_data_count = wcnt.
  - rd_data_count = wcnt×RATIO − beat_idx.
  - empty = (wcnt == 0).
  - full = (wcnt == DEPTH).
- full depends only on stored words, so a write while full is dropped even if the same cycle's read releases a word.
- Dropped write or read: no state change, and dout holds its value.
- M_Ready <= (rd_data_count ≥ M_count), compared unsigned at CW width. M_count = 0 makes M_Ready 1 whenever out of reset.
- S_Ready <= (wcnt < S_THRESH).
- Next_Reg (rst low): clears wr_ptr, rd_ptr, beat_idx and wcnt. Writes and reads in that cycle are discarded. dout holds its value. M_Ready and S_Ready recompute from the cleared counts on the next edge.
- Memory contents are never reset.

## Timing
- Reset values: dout 0, M_Ready 0, S_Ready 1, empty 1, full 0, wr_data_count 0, rd_data_count 0, all pointers 0.
- Mid-operation rst: everything above is cleared on the same edge, and in-flight data is lost.
- Write-to-readable latency: the counts and empty change on the edge after wr_en is sampled. A rd_en in the following cycle returns that word's beat 0.
- Read latency: dout updates on the edge that samples rd_en and is valid in the next cycle. Back-to-back rd_en gives one beat per cycle with no bubbles across wide-word boundaries.
- M_Ready and S_Ready lag the counts by exactly one cycle. The front end must tolerate up to 1 extra write after S_Ready falls; S_THRESH < DEPTH guarantees the room.
- Sustained throughput: 1 wide write per RATIO cycles matches 1 read per cycle.

## Test plan
- Reset then idle:
  - Expected: empty=1, S_Ready=1, M_Ready=0, counts 0.
  - Apply rd_en: dout stays 0 and the counts do not move.
- Single word: write din = {8 beats 0x7..0x0, each replicated}, then 8 consecutive rd_en.
  - Expected: dout = beats 0,1,…,7 on consecutive cycles.
  - rd_data_count steps 8→0, empty=1 after the 8th read.
- Fill: 128 writes with no reads.
  - Expected: full=1, wr_data_count=128, rd_data_count=1024.
  - S_Ready falls one cycle after wcnt reaches 120.
  - A 129th write is dropped: reading all 1024 beats returns words 0..127 in order.
- Concurrent flow:
  - M_count=16. M_Ready rises one cycle after the 2nd wide write.
  - Then write 1 word per 8 cycles while reading every cycle. Expected: no drops, wcnt stays bounded, pointers wrap past 127 with correct data.
- Simultaneous write and releasing read at wcnt=1, beat_idx=7.
  - Expected: wcnt stays 1 and rd_data_count becomes 8.
- Next_Reg mid-stream at wcnt=5, beat_idx=3.
  - Expected: next cycle counts are 0 and empty=1. M_Ready falls and S_Ready=1 one cycle later.
  - The next written word reads back starting from its beat 0.
